// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory request/response bus
//
// Purpose: groups the fetch stage's instruction-memory handshake.
// Signals:
//   imem_req   fetch side -> memory  request, held high until imem_ack
//   imem_addr  fetch side -> memory  16-bit fetch address
//   imem_ack   memory -> fetch side  response valid (same cycle or later)
//   imem_rdata memory -> fetch side  16-bit instruction word, valid with ack
// Modports: master = fetch stage, slave = instruction memory.

interface if_fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - pipeline instruction fetch stage with IF/ID register
//
// Purpose: fetches 16-bit instructions from a variable-latency memory,
// honours stall/flush/redirect from the hazard unit and fills IF/ID.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   stall               freeze PC and IF/ID
//   flush               squash IF/ID to a NOP bubble
//   pc_src              redirect next fetch to branch_target
//   branch_target[15:0] redirect address
//   imem                instruction memory bus (master side)
//   ifid_out[31:0]      {fetch PC+2, instruction}
//   ifid_valid          IF/ID holds a real instruction
//   pc_out[15:0]        current PC
//   fetch_busy          memory request outstanding without ack

module if_fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    pc_src,
  input  logic [15:0]             branch_target,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             ifid_out,
  output logic                    ifid_valid,
  output logic [15:0]             pc_out,
  output logic                    fetch_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] drain_addr, drain_addr_nx;
  logic [31:0] hold_buf, hold_buf_nx;
  logic [31:0] ifid_nx;
  logic        ifid_valid_nx;
  logic [15:0] pc_plus2;
  logic        req;

  // Wraps modulo 2^16 by width.
  assign pc_plus2 = pc + 16'd2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= 16'h0000;
      hold_buf   <= 32'h0000_0000;
      ifid_out   <= {16'h0000, NOP_INSTR};
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      drain_addr <= drain_addr_nx;
      hold_buf   <= hold_buf_nx;
      ifid_out   <= ifid_nx;
      ifid_valid <= ifid_valid_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    hold_buf_nx   = hold_buf;
    ifid_nx       = ifid_out;
    ifid_valid_nx = ifid_valid;

    case (state)
      IDLE: begin
        state_nx = FETCH;
      end

      FETCH: begin
        if (pc_src) begin
          // Redirect wins over stall; the word in flight is not used.
          pc_nx = branch_target;
          if (!imem.imem_ack) begin
            // Memory still owes us a response for the old address: keep
            // presenting it until the ack arrives, then drop the data.
            state_nx      = DRAIN;
            drain_addr_nx = pc;
          end
        end else if (imem.imem_ack && !stall) begin
          ifid_nx       = {pc_plus2, imem.imem_rdata};
          ifid_valid_nx = 1'b1;
          pc_nx         = pc_plus2;
        end else if (imem.imem_ack) begin
          // Data arrived while ID is frozen; park it until stall drops.
          hold_buf_nx = {pc_plus2, imem.imem_rdata};
          state_nx    = HOLD;
        end else if (!stall) begin
          ifid_nx       = {pc_plus2, NOP_INSTR};
          ifid_valid_nx = 1'b0;
        end
      end

      HOLD: begin
        if (pc_src) begin
          pc_nx    = branch_target;
          state_nx = FETCH;
        end else if (!stall) begin
          ifid_nx       = hold_buf;
          ifid_valid_nx = 1'b1;
          pc_nx         = pc_plus2;
          state_nx      = FETCH;
        end
      end

      DRAIN: begin
        if (pc_src) begin
          pc_nx = branch_target;
        end
        // An ack in the same cycle as a new redirect still retires the old
        // request, so the next fetch goes straight to the newest target.
        if (imem.imem_ack) begin
          state_nx = FETCH;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    if (flush) begin
      ifid_nx       = {16'h0000, NOP_INSTR};
      ifid_valid_nx = 1'b0;
    end
  end

  assign req            = (state == FETCH) || (state == DRAIN);
  assign imem.imem_req  = req;
  assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign fetch_busy     = req && !imem.imem_ack;
  assign pc_out         = pc;

endmodule
